// File: rtl/calc_host_pkg.sv
// Shared types and constants for the calculator host port: FSM states, flag codes, default addresses.
package calc_host_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_OP,
        WR_GO,
        POLL,
        POLL_CHK,
        RD_RES,
        RD_CAP,
        CLR_FLAG,
        DONE
    } state_t;

    localparam logic [31:0] FLAG_IDLE = 32'd0;
    localparam logic [31:0] FLAG_GO   = 32'd1;
    localparam logic [31:0] FLAG_DONE = 32'd2;

    localparam logic [31:0] DEF_A_ADDR    = 32'h0000_0040;
    localparam logic [31:0] DEF_B_ADDR    = 32'h0000_0044;
    localparam logic [31:0] DEF_OP_ADDR   = 32'h0000_0048;
    localparam logic [31:0] DEF_FLAG_ADDR = 32'h0000_004C;
    localparam logic [31:0] DEF_RES_ADDR  = 32'h0000_0050;

endpackage

// File: rtl/calc_poll_timer.sv
// Saturating count of failed flag polls; expired means the poll now being judged is the LIMIT-th.
// Single-cycle update, no backpressure; clear wins over inc.
module calc_poll_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q >= W'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/calc_host_port.sv
// Writes operands/opcode to data memory, raises GO, polls for DONE, reads the result; 10 cycles minimum.
// start is only sampled in IDLE (no queueing); CALC_TIMEOUT_EN adds a bounded poll with error report.
module calc_host_port
    import calc_host_pkg::*;
#(
    parameter logic [31:0] A_ADDR        = DEF_A_ADDR,
    parameter logic [31:0] B_ADDR        = DEF_B_ADDR,
    parameter logic [31:0] OP_ADDR       = DEF_OP_ADDR,
    parameter logic [31:0] FLAG_ADDR     = DEF_FLAG_ADDR,
    parameter logic [31:0] RES_ADDR      = DEF_RES_ADDR,
    parameter int          TIMEOUT_POLLS = 1024
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [3:0]  opcode,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic        error,
    output logic [31:0] EntradaCalcu,
    output logic [31:0] addressCalcu,
    output logic        writeEnableCalcu,
    input  logic [31:0] resultadoCalcu
);

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d;
    logic        busy_q, busy_d, rv_q, rv_d, err_q, err_d, to_q, to_d, we_q, we_d;
    logic [31:0] result_q, result_d, wdat_q, wdat_d, addr_q, addr_d;

`ifdef CALC_TIMEOUT_EN
    logic tmr_clear, tmr_inc, tmr_expired;

    calc_poll_timer #(.LIMIT(TIMEOUT_POLLS)) u_poll_timer (
        .clk     (CLK),
        .rst     (RST),
        .clear   (tmr_clear),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_POLLS;
`endif

    // Memory outputs are registered from the current state, so they lag the state by one cycle.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        rv_d     = rv_q;
        err_d    = err_q;
        to_d     = to_q;
        busy_d   = 1'b0;
        we_d     = 1'b0;
        wdat_d   = '0;
        addr_d   = '0;
`ifdef CALC_TIMEOUT_EN
        tmr_clear = 1'b0;
        tmr_inc   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WR_A;
                    a_d     = op_a;
                    b_d     = op_b;
                    op_d    = opcode;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    to_d    = 1'b0;
                    busy_d  = 1'b1;
`ifdef CALC_TIMEOUT_EN
                    tmr_clear = 1'b1;
`endif
                end
            end
            WR_A: begin
                busy_d = 1'b1; we_d = 1'b1; addr_d = A_ADDR; wdat_d = a_q;
                state_d = WR_B;
            end
            WR_B: begin
                busy_d = 1'b1; we_d = 1'b1; addr_d = B_ADDR; wdat_d = b_q;
                state_d = WR_OP;
            end
            WR_OP: begin
                busy_d = 1'b1; we_d = 1'b1; addr_d = OP_ADDR; wdat_d = {28'h0, op_q};
                state_d = WR_GO;
            end
            WR_GO: begin
                busy_d = 1'b1; we_d = 1'b1; addr_d = FLAG_ADDR; wdat_d = FLAG_GO;
                state_d = POLL;
            end
            POLL: begin
                busy_d = 1'b1; addr_d = FLAG_ADDR;
                state_d = POLL_CHK;
            end
            POLL_CHK: begin
                busy_d = 1'b1;
                if (resultadoCalcu == FLAG_DONE) begin
                    state_d = RD_RES;
                end else begin
`ifdef CALC_TIMEOUT_EN
                    if (tmr_expired) begin
                        state_d  = CLR_FLAG;
                        result_d = '0;
                        to_d     = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                        state_d = POLL;
                    end
`else
                    state_d = POLL;
`endif
                end
            end
            RD_RES: begin
                busy_d = 1'b1; addr_d = RES_ADDR;
                state_d = RD_CAP;
            end
            RD_CAP: begin
                busy_d   = 1'b1;
                result_d = resultadoCalcu;
                state_d  = CLR_FLAG;
            end
            CLR_FLAG: begin
                busy_d = 1'b1; we_d = 1'b1; addr_d = FLAG_ADDR; wdat_d = FLAG_IDLE;
                state_d = DONE;
            end
            DONE: begin
                rv_d    = 1'b1;
                err_d   = to_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            rv_q     <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            wdat_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            rv_q     <= rv_d;
            err_q    <= err_d;
            to_q     <= to_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            wdat_q   <= wdat_d;
            addr_q   <= addr_d;
        end
    end

    assign busy             = busy_q;
    assign result_valid     = rv_q;
    assign result           = result_q;
    assign error            = err_q;
    assign EntradaCalcu     = wdat_q;
    assign addressCalcu     = addr_q;
    assign writeEnableCalcu = we_q;

endmodule

// File: doc/calc_host_port.md
# calc_host_port

Host-side sequencer that drives the calculator port of the data memory (`EntradaCalcu`, `addressCalcu`, `writeEnableCalcu`, `resultadoCalcu`) in the `MicroProcessor` top level.

- It accepts an operand pair and an opcode from the user-facing logic and writes them into fixed data-memory words.
- It raises a GO flag, then polls the flag word until the ARM program writes DONE.
- It then reads back the result word, clears the flag, and presents the result with a valid strobe.

## Interface
Parameters:
- `A_ADDR`, default 32'h0000_0040: data-memory byte address of operand A.
- `B_ADDR`, default 32'h0000_0044: operand B address.
- `OP_ADDR`, default 32'h0000_0048: opcode word address.
- `FLAG_ADDR`, default 32'h0000_004C: handshake flag word address.
- `RES_ADDR`, default 32'h0000_0050: result word address.
- `TIMEOUT_POLLS`, default 1024: maximum poll iterations. Used only when `CALC_TIMEOUT_EN` is defined.

Ports:
- `CLK`, in, 1: single clock, rising edge.
- `RST`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: request strobe. Sampled only in IDLE.
- `op_a`, in, 32: operand A, latched on accept.
- `op_b`, in, 32: operand B, latched on accept.
- `opcode`, in, 4: operation code, zero-extended to 32 bits on write.
- `busy`, out, 1: high from the cycle after accept through the CLR_FLAG state.
- `result_valid`, out, 1: high in DONE. Cleared on the next accepted `start`.
- `result`, out, 32: last result. Held until the next accept.
- `error`, out, 1: timeout indication, valid while `result_valid`=1.
- `EntradaCalcu`, out, 32: memory write data.
- `addressCalcu`, out, 32: memory address.
- `writeEnableCalcu`, out, 1: memory write strobe.
- `resultadoCalcu`, in, 32: memory read data. Valid the cycle after `addressCalcu` is driven.

## Operation
Flag codes in the flag word: FLAG_IDLE=0, FLAG_GO=1, FLAG_DONE=2.

FSM states and transitions:
- IDLE -> WR_A when `start`=1. On this transition, latch `op_a`, `op_b`, `opcode`, clear `result_valid` and `error`.
- WR_A: write latched A to `A_ADDR`, `writeEnableCalcu`=1. Go to WR_B.
- WR_B: write latched B to `B_ADDR`. Go to WR_OP.
- WR_OP: write the opcode to `OP_ADDR`. Go to WR_GO.
- WR_GO: write FLAG_GO to `FLAG_ADDR`. Go to POLL.
- POLL: `addressCalcu`=`FLAG_ADDR`, write enable 0. Go to POLL_CHK.
- POLL_CHK: sample `resultadoCalcu`.
  - If it equals FLAG_DONE, go to RD_RES.
  - Otherwise increment the poll counter and go to POLL.
- RD_RES: `addressCalcu`=`RES_ADDR`, write enable 0. Go to RD_CAP.
- RD_CAP: capture `resultadoCalcu` into `result`. Go to CLR_FLAG.
- CLR_FLAG: write FLAG_IDLE to `FLAG_ADDR`. Go to DONE.
- DONE: `result_valid`=1. Go to IDLE on the next cycle, but `result_valid` and `result` stay held until the next accept.

Boundary behaviour:
- `start` outside IDLE is ignored. No queueing.
- Flag values other than 0/1/2 read in POLL_CHK are treated as not-done.
- `writeEnableCalcu` is high only in WR_A, WR_B, WR_OP, WR_GO and CLR_FLAG.
- In all non-write states `EntradaCalcu`=0. In IDLE and DONE, `addressCalcu`=0.
- Reset mid-operation returns the FSM to IDLE and deasserts `writeEnableCalcu` asynchronously. The memory flag word is not cleared by reset.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `result_valid`=0, `result`=0, `error`=0, `EntradaCalcu`=0, `addressCalcu`=0, `writeEnableCalcu`=0. The FSM resets to IDLE and the poll counter to 0.
- Accept edge = the rising edge at which `start`=1 in IDLE.
- Minimum latency (DONE seen on the first poll): `result_valid` rises at the 10th rising edge after the accept edge.
- Each additional poll iteration adds 2 cycles.
- `busy` and `result_valid` are never high in the same cycle.

## Configuration
- Macro: `CALC_TIMEOUT_EN`.
- Defined: when the poll counter reaches `TIMEOUT_POLLS` in POLL_CHK without seeing DONE, go to CLR_FLAG and skip the result read. In DONE, `result`=0 and `error`=1. The counter is cleared on accept.
- Undefined: the block polls indefinitely, `error` is tied to 0, and no counter logic is synthesised.

## Structure
- Package `calc_host_pkg` holds:
  - the state enum (IDLE, WR_A, WR_B, WR_OP, WR_GO, POLL, POLL_CHK, RD_RES, RD_CAP, CLR_FLAG, DONE);
  - FLAG_IDLE/FLAG_GO/FLAG_DONE constants;
  - default address constants.
- One sub-module, `calc_poll_timer`: a saturating poll counter with `clear`, `inc` and `expired` signals. It is instantiated only under `CALC_TIMEOUT_EN`.

## Test plan
- Reset check: pulse `RST` mid-cycle -> all outputs 0 immediately; FSM in IDLE.
- Single operation: A=7, B=5, opcode=1; memory model returns FLAG_DONE on the first poll and 12 at `RES_ADDR` -> expected response:
  - writes 7@0x40, 5@0x44, 1@0x48, 1@0x4C;
  - `result`=12 and `result_valid` at edge 10;
  - 0 written to 0x4C.
- Delayed DONE: flag reads 1,1,1 then 2 -> three extra poll iterations; `result_valid` at edge 16.
- `start` asserted while `busy` -> ignored; operands unchanged in memory; exactly one result.
- Timeout (with `CALC_TIMEOUT_EN`, `TIMEOUT_POLLS`=4): flag stuck at 1 -> four polls, then CLR_FLAG write, `error`=1, `result`=0.
- Back-to-back: `start` in the cycle after DONE -> `result_valid` drops on accept; second operation completes with the new result.
